// File: rtl/fnd_scan_controller_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package fnd_scan_controller_pkg;

    // Scan FSM: SHOW drives one anode, BLANK holds all anodes off.
    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    // Active-low "everything off" values for segments and anodes.
    localparam logic [7:0] FND_OFF   = 8'hFF;
    localparam logic [3:0] ANODE_OFF = 4'b1111;

    // Clearing bit 7 lights the decimal point.
    localparam logic [7:0] DP_MASK   = 8'h7F;

    // Active-low segment patterns for digits 0-9, bit 7 = decimal point.
    localparam logic [7:0] FONT_0 = 8'hC0;
    localparam logic [7:0] FONT_1 = 8'hF9;
    localparam logic [7:0] FONT_2 = 8'hA4;
    localparam logic [7:0] FONT_3 = 8'hB0;
    localparam logic [7:0] FONT_4 = 8'h99;
    localparam logic [7:0] FONT_5 = 8'h92;
    localparam logic [7:0] FONT_6 = 8'h82;
    localparam logic [7:0] FONT_7 = 8'hF8;
    localparam logic [7:0] FONT_8 = 8'h80;
    localparam logic [7:0] FONT_9 = 8'h98;

    // BCD nibble to segment pattern; non-BCD codes render dark.
    function automatic logic [7:0] seg_font(input logic [3:0] nib);
        logic [7:0] f;
        case (nib)
            4'd0:    f = FONT_0;
            4'd1:    f = FONT_1;
            4'd2:    f = FONT_2;
            4'd3:    f = FONT_3;
            4'd4:    f = FONT_4;
            4'd5:    f = FONT_5;
            4'd6:    f = FONT_6;
            4'd7:    f = FONT_7;
            4'd8:    f = FONT_8;
            4'd9:    f = FONT_9;
            default: f = FND_OFF;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/fnd_scan_controller_tick_gen.sv
// Free-running divider producing a one-cycle tick every P_TICK_DIV clocks.
module fnd_tick_gen #(
    parameter int P_TICK_DIV = 100000
) (
    input  logic i_clk,
    input  logic i_reset_n,
    output logic o_tick
);

    localparam int            CW   = (P_TICK_DIV > 1) ? $clog2(P_TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(P_TICK_DIV - 1);

    logic [CW-1:0] cnt_q;

    // Count 0..P_TICK_DIV-1 and wrap.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_q <= '0;
        end else if (cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Tick is high for the single cycle the counter sits at its terminal value.
    assign o_tick = (cnt_q == LAST);

endmodule

// File: rtl/fnd_scan_controller.sv
// Four-digit multiplexed seven-segment scan controller with inter-digit
// blanking, frame-coherent snapshots, clock/fan modes and display-off.
//
// Handshake: none; i_value/i_clock_value are sampled only at a frame start
// (SHOW entry at idx 0), i_switch is resynchronised and sampled at the same
// instant, so a frame always shows one consistent set of inputs.
module fnd_scan_controller
    import fnd_scan_controller_pkg::*;
#(
    parameter int P_TICK_DIV  = 100000,
    parameter int P_BLANK_CYC = 1000,
    parameter int P_LZ_BLANK  = 1
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [15:0] i_value,
    input  logic [15:0] i_clock_value,
    input  logic [1:0]  i_switch,
    output logic [3:0]  o_digit_sel,
    output logic [7:0]  o_font,
    output state_t      o_dbg_state,
    output logic [1:0]  o_dbg_idx
);

    localparam int            BW         = (P_BLANK_CYC > 1) ? $clog2(P_BLANK_CYC) : 1;
    localparam logic [BW-1:0] BLANK_LAST = BW'(P_BLANK_CYC - 1);

    logic          tick;
    state_t        state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [BW-1:0] blank_cnt_q, blank_cnt_d;
    logic          snap;

    logic [1:0]    sw_s1_q, sw_s2_q;
    logic [15:0]   frame_value_q, frame_value_d;
    logic [15:0]   frame_clock_q, frame_clock_d;
    logic          frame_mode_q, frame_mode_d;
    logic          frame_off_q, frame_off_d;

    logic [15:0]   word;
    logic [3:0]    nib;
    logic          lead_zero;
    logic [7:0]    digit_font;
    logic [3:0]    digit_sel_q, digit_sel_d;
    logic [7:0]    font_q, font_d;

    fnd_tick_gen #(
        .P_TICK_DIV(P_TICK_DIV)
    ) u_tick_gen (
        .i_clk    (i_clk),
        .i_reset_n(i_reset_n),
        .o_tick   (tick)
    );

    // Next-state logic: dwell in SHOW until tick, then blank for P_BLANK_CYC
    // cycles. idx advances on leaving SHOW so the first SHOW after reset is idx 0.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        blank_cnt_d = blank_cnt_q;
        snap        = 1'b0;
        case (state_q)
            ST_SHOW: begin
                if (tick) begin
                    state_d = ST_BLANK;
                    idx_d   = idx_q + 2'd1;
                end
            end
            ST_BLANK: begin
                if (blank_cnt_q == BLANK_LAST) begin
                    state_d     = ST_SHOW;
                    blank_cnt_d = '0;
                    snap        = (idx_q == 2'd0);
                end else begin
                    blank_cnt_d = blank_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_BLANK;
        endcase
    end

    // FSM, digit index and blank counter registers.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= ST_BLANK;
            idx_q       <= 2'd0;
            blank_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            blank_cnt_q <= blank_cnt_d;
        end
    end

    // Two-flop synchronizer for the asynchronous mode switches.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sw_s1_q <= 2'b00;
            sw_s2_q <= 2'b00;
        end else begin
            sw_s1_q <= i_switch;
            sw_s2_q <= sw_s1_q;
        end
    end

    // Frame snapshot taken only on entry to SHOW at idx 0.
    always_comb begin
        frame_value_d = frame_value_q;
        frame_clock_d = frame_clock_q;
        frame_mode_d  = frame_mode_q;
        frame_off_d   = frame_off_q;
        if (snap) begin
            frame_value_d = i_value;
            frame_clock_d = i_clock_value;
            frame_mode_d  = sw_s2_q[0];
            frame_off_d   = sw_s2_q[1];
        end
    end

    // Frame registers.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            frame_value_q <= 16'h0000;
            frame_clock_q <= 16'h0000;
            frame_mode_q  <= 1'b0;
            frame_off_q   <= 1'b0;
        end else begin
            frame_value_q <= frame_value_d;
            frame_clock_q <= frame_clock_d;
            frame_mode_q  <= frame_mode_d;
            frame_off_q   <= frame_off_d;
        end
    end

    // Output decode from next-state values so the registered anodes and
    // segments always change together with the FSM.
    always_comb begin
        word      = frame_mode_d ? frame_clock_d : frame_value_d;
        nib       = word[3:0];
        lead_zero = 1'b0;
        case (idx_d)
            2'd0: begin nib = word[3:0];   lead_zero = 1'b0;                 end
            2'd1: begin nib = word[7:4];   lead_zero = (word[15:4]  == '0);  end
            2'd2: begin nib = word[11:8];  lead_zero = (word[15:8]  == '0);  end
            default: begin nib = word[15:12]; lead_zero = (word[15:12] == '0); end
        endcase

        digit_font = seg_font(nib);
        if (frame_mode_d && (idx_d == 2'd2)) begin
            digit_font = digit_font & DP_MASK;
        end
        if (!frame_mode_d && (P_LZ_BLANK != 0) && lead_zero) begin
            digit_font = FND_OFF;
        end

        digit_sel_d = ANODE_OFF;
        font_d      = FND_OFF;
        if ((state_d == ST_SHOW) && !frame_off_d) begin
            digit_sel_d = ~(4'b0001 << idx_d);
            font_d      = digit_font;
        end
    end

    // Registered anode and segment outputs.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            digit_sel_q <= ANODE_OFF;
            font_q      <= FND_OFF;
        end else begin
            digit_sel_q <= digit_sel_d;
            font_q      <= font_d;
        end
    end

    assign o_digit_sel = digit_sel_q;
    assign o_font      = font_q;
    assign o_dbg_state = state_q;
    assign o_dbg_idx   = idx_q;

endmodule
